imem_fetch_ctrl: RTL and testbench

Fetch controller and access arbiter for the mini-CPU instruction memory. It owns the single address port of the instruction memory. It sequences program loading: a stream of instruction bytes is written from address 0 upward. It then runs the fetch stream: a program counter drives the memory, and fetched instructions go to decode over a valid/ready handshake, with redirect (branch/jump) and halt handling. It sits between the boot/debug loader, the instruction memory and the decode stage.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/imem_fetch_ctrl_if.sv | 24 ++
 rtl/fetch_out_reg.sv | 42 ++++
 rtl/imem_fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared mini-CPU constants and the instruction-fetch state type.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 8;

    // Unwritten memory reads as zero, so running off a program halts.
    localparam logic [INSTR_W-1:0] OPC_HALT = 8'h00;

    typedef enum logic [1:0] {
        HALTED,
        LOADING,
        RUNNING
    } fetch_state_t;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-to-decode handshake: instruction word, its address and valid/ready.
interface imem_fetch_ctrl_if;
    import cpu_pkg::*;

    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;

    modport master (
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );

endinterface

// File: rtl/fetch_out_reg.sv
// Valid/ready output register for fetched words; flush drops the held word.
module fetch_out_reg
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               load_en,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc,
    output logic               loadable,
    imem_fetch_ctrl_if.master  dec
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_q;

    assign loadable = !valid_q || dec.instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (loadable) begin
            // An accepted word with nothing behind it simply empties the register.
            valid_q <= load_en;
            if (load_en) begin
                instr_q <= in_instr;
                pc_q    <= in_pc;
            end
        end
    end

    assign dec.instr       = instr_q;
    assign dec.instr_pc    = pc_q;
    assign dec.instr_valid = valid_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory fetch controller: owns the memory port, sequences program
// loading from address 0 and streams fetched words to decode.
module imem_fetch_ctrl
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,

    input  logic               load_start,
    input  logic               ld_valid,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic               ld_last,
    output logic               ld_ready,

    input  logic               run_start,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic               halt_req,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,

    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [INSTR_W-1:0] mem_wdata,
    input  logic [INSTR_W-1:0] mem_rdata,

    imem_fetch_ctrl_if.master  dec,
    output logic               halted
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
    logic              flush;
    logic              fetch_en;
    logic              out_loadable;
    logic              halt_word;

    // A presented HALT word stops fetching until decode takes it or a redirect.
    assign halt_word = dec.instr_valid && (dec.instr == OPC_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HALTED;
            pc_q     <= '0;
            ld_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ld_ptr_q <= ld_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ld_ptr_d  = ld_ptr_q;
        flush     = 1'b0;
        fetch_en  = 1'b0;
        mem_addr  = pc_q;
        mem_we    = 1'b0;
        mem_wdata = ld_data;

        unique case (state_q)
            HALTED: begin
                if (load_start) begin
                    state_d  = LOADING;
                    ld_ptr_d = '0;
                end else if (run_start) begin
                    state_d = RUNNING;
                    pc_d    = start_addr;
                end
            end
            LOADING: begin
                mem_addr = ld_ptr_q;
                if (ld_valid) begin
                    mem_we   = 1'b1;
                    ld_ptr_d = ld_ptr_q + ADDR_W'(1);
                    if (ld_last) begin
                        state_d = HALTED;
                    end
                end
            end
            RUNNING: begin
                if (redirect_valid) begin
                    pc_d  = redirect_addr;
                    flush = 1'b1;
                end else if (halt_word) begin
                    if (dec.instr_ready) begin
                        state_d = HALTED;
                        flush   = 1'b1;
                    end
                end else if (out_loadable) begin
                    fetch_en = 1'b1;
                    pc_d     = pc_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = HALTED;
            end
        endcase

        if (halt_req) begin
            state_d  = HALTED;
            pc_d     = pc_q;
            ld_ptr_d = ld_ptr_q;
            flush    = 1'b1;
            fetch_en = 1'b0;
            mem_we   = 1'b0;
        end
    end

    fetch_out_reg u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .load_en  (fetch_en),
        .in_instr (mem_rdata),
        .in_pc    (pc_q),
        .loadable (out_loadable),
        .dec      (dec)
    );

    assign ld_ready = (state_q == LOADING);
    assign halted   = (state_q == HALTED);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios plus randomized
// load/run sessions checked against a memory-image walk model.
module tb_imem_fetch_ctrl;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_start = 1'b0;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data = 8'h00;
    logic       ld_last = 1'b0;
    logic       ld_ready;
    logic       run_start = 1'b0;
    logic [7:0] start_addr = 8'h00;
    logic       halt_req = 1'b0;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_addr = 8'h00;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       halted;

    imem_fetch_ctrl_if dec ();

    // Environment memory with combinational read.
    logic [7:0] mem [256] = '{default: 8'h00};
    // Model: what the program image should hold after the loads issued.
    logic [7:0] img [256];
    logic [7:0] prog [$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    imem_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .load_start     (load_start),
        .ld_valid       (ld_valid),
        .ld_data        (ld_data),
        .ld_last        (ld_last),
        .ld_ready       (ld_ready),
        .run_start      (run_start),
        .start_addr     (start_addr),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .dec            (dec),
        .halted         (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_halted", 32'(halted), 32'(1));
        check("rst_valid", 32'(dec.instr_valid), 32'(0));
        check("rst_instr", 32'(dec.instr), 32'(0));
        check("rst_pc", 32'(dec.instr_pc), 32'(0));
        check("rst_addr", 32'(mem_addr), 32'(0));
        check("rst_we", 32'(mem_we), 32'(0));
        check("rst_ld_ready", 32'(ld_ready), 32'(0));
    endtask

    // Writes prog[] from address 0, ld_last on the final byte.
    task automatic load_prog();
        logic [7:0] ptr;
        ptr = 8'h00;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("ld_ready", 32'(ld_ready), 32'(1));
        foreach (prog[i]) begin
            ld_valid = 1'b1;
            ld_data  = prog[i];
            ld_last  = (i == prog.size() - 1);
            #1;
            check("ld_we", 32'(mem_we), 32'(1));
            check("ld_addr", 32'(mem_addr), 32'(ptr));
            step();
            img[ptr] = prog[i];
            ptr++;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("ld_done_halted", 32'(halted), 32'(1));
    endtask

    // Runs from start with random backpressure and redirects (targets <= rmax);
    // every accepted word must follow the image walk until a HALT is consumed.
    task automatic run_check(input logic [7:0] start, input int unsigned rmax,
                             input int unsigned ready_pct, input int unsigned redir_pct);
        logic [7:0] exp_pc, raddr, hold_instr, hold_pc;
        logic       hold, rdy, redir, acc, done;
        int         cyc;
        exp_pc = start;
        hold   = 1'b0;
        done   = 1'b0;
        cyc    = 0;
        start_addr = start;
        run_start  = 1'b1;
        step();
        run_start  = 1'b0;
        check("run_addr", 32'(mem_addr), 32'(start));
        while (!done && cyc < 2000) begin
            cyc++;
            rdy   = ($urandom_range(99) < ready_pct);
            redir = ($urandom_range(99) < redir_pct);
            raddr = 8'($urandom_range(rmax));
            if (hold) begin
                check("hold_valid", 32'(dec.instr_valid), 32'(1));
                check("hold_instr", 32'(dec.instr), 32'(hold_instr));
                check("hold_pc", 32'(dec.instr_pc), 32'(hold_pc));
            end
            acc = dec.instr_valid && rdy;
            if (acc) begin
                check("acc_pc", 32'(dec.instr_pc), 32'(exp_pc));
                check("acc_instr", 32'(dec.instr), 32'(img[exp_pc]));
            end
            dec.instr_ready = rdy;
            redirect_valid  = redir;
            redirect_addr   = raddr;
            hold       = dec.instr_valid && !rdy && !redir;
            hold_instr = dec.instr;
            hold_pc    = dec.instr_pc;
            step();
            redirect_valid = 1'b0;
            if (redir) begin
                check("redir_bubble", 32'(dec.instr_valid), 32'(0));
                check("redir_addr", 32'(mem_addr), 32'(raddr));
                exp_pc = raddr;
            end else if (acc) begin
                if (img[exp_pc] == OPC_HALT) begin
                    check("halt_state", 32'(halted), 32'(1));
                    check("halt_valid", 32'(dec.instr_valid), 32'(0));
                    done = 1'b1;
                end
                exp_pc++;
            end
        end
        check("run_finished", 32'(done), 32'(1));
        dec.instr_ready = 1'b0;
    endtask

    initial begin
        dec.instr_ready = 1'b0;
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        do_reset();

        // Load then run at full throughput.
        prog.delete();
        prog.push_back(8'h12); prog.push_back(8'h23); prog.push_back(8'h19); prog.push_back(8'h00);
        load_prog();
        start_addr = 8'h00;
        run_start  = 1'b1;
        step();
        run_start  = 1'b0;
        check("t1_addr", 32'(mem_addr), 32'(0));
        check("t1_bubble", 32'(dec.instr_valid), 32'(0));
        dec.instr_ready = 1'b1;
        step();
        check("t1_v0", 32'(dec.instr_valid), 32'(1));
        check("t1_w0", 32'({dec.instr_pc, dec.instr}), 32'h0012);
        step();
        check("t1_w1", 32'({dec.instr_pc, dec.instr}), 32'h0123);
        step();
        check("t1_w2", 32'({dec.instr_pc, dec.instr}), 32'h0219);
        step();
        check("t1_w3", 32'({dec.instr_pc, dec.instr}), 32'h0300);
        check("t1_v3", 32'(dec.instr_valid), 32'(1));
        step();
        check("t1_halted", 32'(halted), 32'(1));
        check("t1_vend", 32'(dec.instr_valid), 32'(0));
        dec.instr_ready = 1'b0;

        // Backpressure: word at pc 0 must hold for 3 cycles.
        start_addr = 8'h00;
        run_start  = 1'b1;
        step();
        run_start  = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_instr", 32'(dec.instr), 32'h12);
            check("bp_pc", 32'(dec.instr_pc), 32'(0));
            check("bp_fetch_pc", 32'(mem_addr), 32'(1));
        end
        dec.instr_ready = 1'b1;
        step();
        dec.instr_ready = 1'b0;
        check("bp_next", 32'({dec.instr_valid, dec.instr_pc, dec.instr}), 32'h10123);
        // halt_req wins over a simultaneous redirect.
        halt_req = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr = 8'h02;
        step();
        halt_req = 1'b0;
        redirect_valid = 1'b0;
        check("hr_halted", 32'(halted), 32'(1));
        check("hr_valid", 32'(dec.instr_valid), 32'(0));

        // Redirect with one bubble, then redirect out of a pending HALT.
        prog.delete();
        for (int i = 0; i < 20; i++) prog.push_back(8'(8'h30 + i));
        prog.push_back(8'h00);
        load_prog();
        start_addr = 8'h00;
        run_start  = 1'b1;
        step();
        run_start  = 1'b0;
        step();
        dec.instr_ready = 1'b1;
        step();
        dec.instr_ready = 1'b0;
        check("rd_pc1", 32'(dec.instr_pc), 32'(1));
        redirect_valid = 1'b1;
        redirect_addr  = 8'h10;
        step();
        redirect_valid = 1'b0;
        check("rd_bubble", 32'(dec.instr_valid), 32'(0));
        check("rd_addr", 32'(mem_addr), 32'h10);
        step();
        check("rd_target", 32'({dec.instr_valid, dec.instr_pc, dec.instr}), 32'h11040);
        dec.instr_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (dec.instr_valid && dec.instr == 8'h00) break;
            step();
        end
        dec.instr_ready = 1'b0;
        check("ph_halt_pc", 32'(dec.instr_pc), 32'h14);
        step();
        check("ph_waiting", 32'(halted), 32'(0));
        redirect_valid = 1'b1;
        redirect_addr  = 8'h05;
        step();
        redirect_valid = 1'b0;
        check("ph_bubble", 32'(dec.instr_valid), 32'(0));
        step();
        check("ph_resume", 32'({dec.instr_valid, dec.instr_pc, dec.instr}), 32'h10535);
        // load_start while running is dropped.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("ls_we", 32'(mem_we), 32'(0));
        check("ls_ld_ready", 32'(ld_ready), 32'(0));
        step();
        check("ls_ld_ready2", 32'(ld_ready), 32'(0));
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("ls_halted", 32'(halted), 32'(1));

        // Wrap from 0xFF to 0x00.
        prog.delete();
        for (int i = 0; i < 256; i++) prog.push_back(8'($urandom_range(1, 255)));
        prog[0] = 8'h12;
        prog[1] = 8'h00;
        prog[255] = 8'h55;
        load_prog();
        run_check(8'hFF, 0, 100, 0);

        // halt_req during a load gates the write.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 8'h77;
        halt_req = 1'b1;
        #1;
        check("hl_we", 32'(mem_we), 32'(0));
        step();
        ld_valid = 1'b0;
        halt_req = 1'b0;
        check("hl_halted", 32'(halted), 32'(1));
        check("hl_mem0", 32'(mem[0]), 32'h12);

        // Reset mid-load keeps already-written bytes.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        ld_valid = 1'b1;
        ld_data = 8'hA1; step();
        ld_data = 8'hA2; step();
        ld_data = 8'hA3; step();
        ld_valid = 1'b0;
        do_reset();
        prog.delete();
        prog.push_back(8'hAA);
        load_prog();
        check("rl_mem0", 32'(mem[0]), 32'hAA);
        check("rl_mem1", 32'(mem[1]), 32'hA2);
        check("rl_mem2", 32'(mem[2]), 32'hA3);
        img[1] = 8'hA2;
        img[2] = 8'hA3;

        // Randomized sessions.
        for (int s = 0; s < 8; s++) begin
            int unsigned len;
            len = $urandom_range(1, 30);
            prog.delete();
            for (int i = 0; i < int'(len); i++) prog.push_back(8'($urandom_range(1, 255)));
            prog.push_back(8'h00);
            load_prog();
            run_check(8'($urandom_range(len)), len, $urandom_range(40, 100), 8);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
